// File: rtl/button_step_counter.sv
// Two-button step input: synchronise, debounce, and turn presses into step pulses
// with auto-repeat, driving a 4-bit LED value and a 4-bit wrap count.
module button_step_counter #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 100_000_000,
    parameter int REPEAT_CYCLES   = 20_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic       up_pulse,
    output logic       down_pulse,
    output logic [3:0] value,
    output logic [3:0] wrap_count,
    output logic [1:0] btn_state,
    output logic [3:0] o_dbg_state
);

    localparam logic [31:0] LP_DB_LAST   = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] LP_HOLD_LAST = 32'(HOLD_CYCLES - 1);
    localparam logic [31:0] LP_REP_LAST  = 32'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } step_state_t;

    logic [1:0] w_raw;
    logic [1:0] w_clean;
    logic [1:0] w_step;
    logic [1:0] r_pulse;
    logic [3:0] r_value;
    logic [3:0] r_wrap;

    assign w_raw = {btn_down, btn_up};

    // Index 0 is the up button, index 1 the down button.
    for (genvar g = 0; g < 2; g++) begin : g_btn
        logic        r_sync1;
        logic        r_sync2;
        logic        r_clean;
        logic [31:0] r_db_cnt;
        logic [31:0] r_timer;
        logic [31:0] w_timer_nxt;
        step_state_t r_state;
        step_state_t w_state_nxt;
        logic        w_step_l;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_sync1  <= 1'b0;
                r_sync2  <= 1'b0;
                r_clean  <= 1'b0;
                r_db_cnt <= '0;
            end else begin
                r_sync1 <= w_raw[g];
                r_sync2 <= r_sync1;
                if (r_sync2 == r_clean) begin
                    r_db_cnt <= '0;
                end else if (r_db_cnt == LP_DB_LAST) begin
                    r_clean  <= r_sync2;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 32'd1;
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_state <= ST_IDLE;
                r_timer <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_timer <= w_timer_nxt;
            end
        end

        // Release is checked first so a repeat due as the clean level drops is suppressed.
        always_comb begin
            w_state_nxt = r_state;
            w_timer_nxt = r_timer;
            w_step_l    = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    w_timer_nxt = '0;
                    if (r_clean) begin
                        w_state_nxt = ST_HELD;
                        w_step_l    = 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!r_clean) begin
                        w_state_nxt = ST_IDLE;
                        w_timer_nxt = '0;
                    end else if (r_timer == LP_HOLD_LAST) begin
                        w_state_nxt = ST_REPEAT;
                        w_timer_nxt = '0;
                        w_step_l    = 1'b1;
                    end else begin
                        w_timer_nxt = r_timer + 32'd1;
                    end
                end
                ST_REPEAT: begin
                    if (!r_clean) begin
                        w_state_nxt = ST_IDLE;
                        w_timer_nxt = '0;
                    end else if (r_timer == LP_REP_LAST) begin
                        w_timer_nxt = '0;
                        w_step_l    = 1'b1;
                    end else begin
                        w_timer_nxt = r_timer + 32'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_timer_nxt = '0;
                end
            endcase
        end

        assign w_clean[g]           = r_clean;
        assign w_step[g]            = w_step_l;
        assign o_dbg_state[2*g +: 2] = r_state;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pulse <= 2'b00;
            r_value <= 4'd0;
            r_wrap  <= 4'd0;
        end else begin
            r_pulse <= w_step;
            case (r_pulse)
                2'b01: begin
                    if (r_value == 4'd15) begin
                        r_value <= 4'd0;
                        r_wrap  <= r_wrap + 4'd1;
                    end else begin
                        r_value <= r_value + 4'd1;
                    end
                end
                2'b10: begin
                    if (r_value == 4'd0) begin
                        r_value <= 4'd15;
                        r_wrap  <= r_wrap - 4'd1;
                    end else begin
                        r_value <= r_value - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign up_pulse   = r_pulse[0];
    assign down_pulse = r_pulse[1];
    assign value      = r_value;
    assign wrap_count = r_wrap;
    assign btn_state  = w_clean;

endmodule
